// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises IF fetches and MEM load/stores onto the single RAM port
module mem_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int ACC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic [DATA_W-1:0] if_data_out,
    output logic              if_valid_out,
    input  logic              mem_req_in,
    input  logic              mem_we_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_wdata_in,
    output logic [DATA_W-1:0] mem_rdata_out,
    output logic              mem_done_out,
    output logic              stall_req_out,
    output logic              ram_enable_out,
    output logic              ram_rw_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_wdata_out,
    input  logic [DATA_W-1:0] ram_rdata_in
);

    localparam int CNT_W = $clog2(ACC_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        TURN
    } state_t;

    state_t           state;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic             mem_eligible;
    logic             if_eligible;

    // The requester's done/valid pulse marks a cycle where its still-high request is stale.
    assign mem_eligible  = mem_req_in & ~mem_done_out;
    assign if_eligible   = if_req_in & ~if_valid_out;
    assign stall_req_out = rst & (mem_eligible | if_eligible);

    // The ram_* outputs double as the latched request registers for the access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            owner          <= 1'b0;
            cnt            <= '0;
            if_data_out    <= '0;
            if_valid_out   <= 1'b0;
            mem_rdata_out  <= '0;
            mem_done_out   <= 1'b0;
            ram_enable_out <= 1'b0;
            ram_rw_out     <= 1'b0;
            ram_addr_out   <= '0;
            ram_wdata_out  <= '0;
        end else begin
            if_valid_out <= 1'b0;
            mem_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_eligible) begin
                        owner          <= 1'b1;
                        ram_rw_out     <= mem_we_in;
                        ram_addr_out   <= mem_addr_in;
                        ram_wdata_out  <= mem_wdata_in;
                        cnt            <= '0;
                        ram_enable_out <= 1'b1;
                        state          <= ACCESS;
                    end else if (if_eligible) begin
                        owner          <= 1'b0;
                        ram_rw_out     <= 1'b0;
                        ram_addr_out   <= if_addr_in;
                        ram_wdata_out  <= mem_wdata_in;
                        cnt            <= '0;
                        ram_enable_out <= 1'b1;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        ram_enable_out <= 1'b0;
                        if (!ram_rw_out) begin
                            if (owner) mem_rdata_out <= ram_rdata_in;
                            else       if_data_out   <= ram_rdata_in;
                        end
                        if (owner) mem_done_out <= 1'b1;
                        else       if_valid_out <= 1'b1;
                        state <= ram_rw_out ? TURN : IDLE;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a timeline model
module tb_mem_arbiter;

    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int ACC  = 3;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req_in = 1'b0;
    logic [AW-1:0] if_addr_in = '0;
    logic [DW-1:0] if_data_out;
    logic          if_valid_out;
    logic          mem_req_in = 1'b0;
    logic          mem_we_in = 1'b0;
    logic [AW-1:0] mem_addr_in = '0;
    logic [DW-1:0] mem_wdata_in = '0;
    logic [DW-1:0] mem_rdata_out;
    logic          mem_done_out;
    logic          stall_req_out;
    logic          ram_enable_out;
    logic          ram_rw_out;
    logic [AW-1:0] ram_addr_out;
    logic [DW-1:0] ram_wdata_out;
    logic [DW-1:0] ram_rdata_in = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_data_out   (if_data_out),
        .if_valid_out  (if_valid_out),
        .mem_req_in    (mem_req_in),
        .mem_we_in     (mem_we_in),
        .mem_addr_in   (mem_addr_in),
        .mem_wdata_in  (mem_wdata_in),
        .mem_rdata_out (mem_rdata_out),
        .mem_done_out  (mem_done_out),
        .stall_req_out (stall_req_out),
        .ram_enable_out(ram_enable_out),
        .ram_rw_out    (ram_rw_out),
        .ram_addr_out  (ram_addr_out),
        .ram_wdata_out (ram_wdata_out),
        .ram_rdata_in  (ram_rdata_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Timeline model: each accepted request occupies a fixed window of cycles.
    int            acc_start = -100;
    int            acc_end   = -100;
    int            pulse_c   = -100;
    int            free_c    = 0;
    int            rst_left  = 0;
    bit            did_mid_rst = 0;
    bit            m_owner, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] cap = '0;
    logic [DW-1:0] exp_if = '0;
    logic [DW-1:0] exp_mem = '0;
    bit            prev_done = 0, prev_valid = 0;
    bit            en_e, v_e, d_e, stall_e, mem_el, if_el;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_enable", 32'(ram_enable_out), 32'd0);
        check_eq("rst_rw",     32'(ram_rw_out),     32'd0);
        check_eq("rst_addr",   32'(ram_addr_out),   32'd0);
        check_eq("rst_wdata",  32'(ram_wdata_out),  32'd0);
        check_eq("rst_valid",  32'(if_valid_out),   32'd0);
        check_eq("rst_done",   32'(mem_done_out),   32'd0);
        check_eq("rst_ifdata", 32'(if_data_out),    32'd0);
        check_eq("rst_memdata",32'(mem_rdata_out),  32'd0);
        check_eq("rst_stall",  32'(stall_req_out),  32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        mem_req_in   = 1'b1;
        mem_we_in    = 1'b1;
        mem_addr_in  = 18'h0BF00;
        mem_wdata_in = 16'h1234;
        if_req_in    = 1'b1;
        if_addr_in   = 18'h00100;
        ram_rdata_in = 16'h4A21;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                rst = 1'b1;
            end else if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) begin
                    rst    = 1'b1;
                    free_c = c;
                end
            end
            if (c >= 12) ram_rdata_in = DW'($urandom);
            if (c > 0) begin
                if (mem_req_in && prev_done)
                    mem_req_in = (c >= 12) && ($urandom_range(3) == 0);
                else if (!mem_req_in && $urandom_range(3) == 0) begin
                    mem_req_in   = 1'b1;
                    mem_we_in    = 1'($urandom_range(1));
                    mem_addr_in  = AW'($urandom);
                    mem_wdata_in = DW'($urandom);
                end
                if (if_req_in && prev_valid)
                    if_req_in = (c >= 12) && ($urandom_range(3) == 0);
                else if (!if_req_in && $urandom_range(1) == 0) begin
                    if_req_in  = 1'b1;
                    if_addr_in = AW'($urandom);
                end
            end

            @(negedge clk);
            if (!rst) begin
                check_reset_outputs();
                prev_done  = 0;
                prev_valid = 0;
            end else begin
                en_e = (c >= acc_start) && (c <= acc_end);
                v_e  = (c == pulse_c) && !m_owner;
                d_e  = (c == pulse_c) && m_owner;
                if (c == pulse_c && !m_we) begin
                    if (m_owner) exp_mem = cap;
                    else         exp_if  = cap;
                end
                stall_e = (mem_req_in && !d_e) || (if_req_in && !v_e);
                check_eq("ram_enable", 32'(ram_enable_out), 32'(en_e));
                check_eq("if_valid",   32'(if_valid_out),   32'(v_e));
                check_eq("mem_done",   32'(mem_done_out),   32'(d_e));
                check_eq("stall",      32'(stall_req_out),  32'(stall_e));
                check_eq("if_data",    32'(if_data_out),    32'(exp_if));
                check_eq("mem_rdata",  32'(mem_rdata_out),  32'(exp_mem));
                if (en_e) begin
                    check_eq("ram_rw",   32'(ram_rw_out),   32'(m_we));
                    check_eq("ram_addr", 32'(ram_addr_out), 32'(m_addr));
                    if (m_we) check_eq("ram_wdata", 32'(ram_wdata_out), 32'(m_wdata));
                end
                if (c == acc_end) cap = ram_rdata_in;
                prev_done  = d_e;
                prev_valid = v_e;

                if (!did_mid_rst && c >= 1500 && en_e) begin
                    rst = 1'b0;
                    #1;
                    check_eq("midrst_enable", 32'(ram_enable_out), 32'd0);
                    check_eq("midrst_valid",  32'(if_valid_out),   32'd0);
                    check_eq("midrst_done",   32'(mem_done_out),   32'd0);
                    did_mid_rst = 1;
                    rst_left    = 3;
                    acc_start   = -100;
                    acc_end     = -100;
                    pulse_c     = -100;
                    exp_if      = '0;
                    exp_mem     = '0;
                    prev_done   = 0;
                    prev_valid  = 0;
                end else if (c >= free_c) begin
                    mem_el = mem_req_in && !d_e;
                    if_el  = if_req_in && !v_e;
                    if (mem_el || if_el) begin
                        m_owner   = mem_el;
                        m_we      = mem_el ? mem_we_in : 1'b0;
                        m_addr    = mem_el ? mem_addr_in : if_addr_in;
                        m_wdata   = mem_wdata_in;
                        acc_start = c + 1;
                        acc_end   = c + ACC;
                        pulse_c   = c + ACC + 1;
                        free_c    = pulse_c + (m_we ? 1 : 0);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
